// File: rtl/mem_region_router.sv
`default_nettype none
// =============================================================================
// Module   : mem_region_router
// Brief    : Routes the processor memory port to one of NREG back-ends by
//            address region. It returns a registered acknowledge and read data,
//            times out stalled transactions, and releases the back-end reset a
//            fixed number of cycles after the memory reset request drops.
// Revision : 1.0  initial release
// =============================================================================
module mem_region_router #(
    parameter int                 NREG    = 2,
    parameter int                 AW      = 21,
    parameter int                 DW      = 16,
    parameter logic [NREG*AW-1:0] BASE    = {21'h010000, 21'h000000},
    parameter int                 TMO     = 255,
    parameter int                 RST_DLY = 3
) (
    input  logic                clk_p,
    input  logic                rst_n,
    input  logic                m_reset,
    input  logic                m_stb,
    input  logic                m_we,
    input  logic [DW/8-1:0]     m_sel,
    input  logic [AW:1]         m_adr,
    input  logic [DW-1:0]       m_out,
    output logic [DW-1:0]       m_dat,
    output logic                m_ack,
    output logic                m_err,
    output logic                m_ready,
    output logic [NREG-1:0]     r_stb,
    output logic                r_we,
    output logic [DW/8-1:0]     r_sel,
    output logic [DW/8-1:0]     r_dqm,
    output logic [AW:1]         r_adr,
    output logic [DW-1:0]       r_wdat,
    input  logic [NREG*DW-1:0]  r_rdat,
    input  logic [NREG-1:0]     r_ack,
    input  logic [NREG-1:0]     r_ready,
    output logic [NREG-1:0]     r_rst_n
);

    localparam int BW  = DW / 8;
    localparam int IW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW  = $clog2(TMO + 1);
    localparam int DLW = (RST_DLY > 0) ? $clog2(RST_DLY + 1) : 1;

    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [DLW-1:0] DLY_LAST = DLW'(RST_DLY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Synchroniser resets to "reset requested" so back-ends stay held until
    // the block has seen a clean, synchronised deassertion.
    logic [1:0]      sync_q,  sync_d;
    logic [DLW-1:0]  dly_q,   dly_d;
    logic            rrst_q,  rrst_d;
    logic            ready_q, ready_d;
    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [NREG-1:0] stb_q,   stb_d;
    logic            we_q,    we_d;
    logic [BW-1:0]   sel_q,   sel_d;
    logic [BW-1:0]   dqm_q,   dqm_d;
    logic [AW:1]     adr_q,   adr_d;
    logic [DW-1:0]   wdat_q,  wdat_d;
    logic [DW-1:0]   dat_q,   dat_d;
    logic            ack_q,   ack_d;
    logic            err_q,   err_d;

    logic            rs;
    logic [IW-1:0]   region_idx;

    assign rs = sync_q[1];

    // Region decode: the highest region whose base is not above the address.
    always_comb begin
        region_idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (m_adr >= BASE[i*AW +: AW]) begin
                region_idx = IW'(i);
            end
        end
    end

    // Next-state logic for reset sequencing and the transaction FSM.
    always_comb begin
        sync_d  = {sync_q[0], m_reset};
        dly_d   = dly_q;
        rrst_d  = rrst_q;
        ready_d = (&r_ready) & rrst_q;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dqm_d   = dqm_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        dat_d   = dat_q;
        ack_d   = ack_q;
        err_d   = err_q;

        if (rs) begin
            // Memory reset overrides everything, including an open transaction.
            dly_d   = '0;
            rrst_d  = 1'b0;
            state_d = IDLE;
            stb_d   = '0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (dly_q != DLY_LAST) begin
                dly_d = dly_q + 1'b1;
            end
            rrst_d = (dly_q == DLY_LAST);

            case (state_q)
                IDLE: begin
                    if (m_stb) begin
                        state_d = ACTIVE;
                        idx_d   = region_idx;
                        we_d    = m_we;
                        sel_d   = m_sel;
                        dqm_d   = m_we ? ~m_sel : '0;
                        adr_d   = m_adr;
                        wdat_d  = m_out;
                        stb_d   = NREG'(1) << region_idx;
                        cnt_d   = '0;
                    end
                end
                ACTIVE: begin
                    // Master abort beats a same-cycle ack; only the selected
                    // region's ack is honoured.
                    if (!m_stb) begin
                        state_d = IDLE;
                        stb_d   = '0;
                    end else if (r_ack[idx_q]) begin
                        state_d = DONE;
                        stb_d   = '0;
                        ack_d   = 1'b1;
                        err_d   = 1'b0;
                        dat_d   = we_q ? '0 : r_rdat[int'(idx_q)*DW +: DW];
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = DONE;
                        stb_d   = '0;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dat_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!m_stb) begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stb_d   = '0;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            dly_q   <= '0;
            rrst_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dqm_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            dly_q   <= dly_d;
            rrst_q  <= rrst_d;
            ready_q <= ready_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dqm_q   <= dqm_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign m_dat   = dat_q;
    assign m_ack   = ack_q;
    assign m_err   = err_q;
    assign m_ready = ready_q;
    assign r_stb   = stb_q;
    assign r_we    = we_q;
    assign r_sel   = sel_q;
    assign r_dqm   = dqm_q;
    assign r_adr   = adr_q;
    assign r_wdat  = wdat_q;
    assign r_rst_n = {NREG{rrst_q}};

endmodule
`default_nettype wire

// File: tb/tb_mem_region_router.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_region_router
// Brief    : Scoreboard bench for mem_region_router with a behavioural
//            reference for region decode, byte mask and response data.
// Revision : 1.0  initial release
// =============================================================================
module tb_mem_region_router;

    localparam int NREG    = 2;
    localparam int AW      = 21;
    localparam int DW      = 16;
    localparam int BW      = DW / 8;
    localparam int TMO     = 16;
    localparam int RST_DLY = 3;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } exp_t;

    logic                clk_p = 1'b0;
    logic                rst_n;
    logic                m_reset;
    logic                m_stb;
    logic                m_we;
    logic [BW-1:0]       m_sel;
    logic [AW:1]         m_adr;
    logic [DW-1:0]       m_out;
    logic [DW-1:0]       m_dat;
    logic                m_ack;
    logic                m_err;
    logic                m_ready;
    logic [NREG-1:0]     r_stb;
    logic                r_we;
    logic [BW-1:0]       r_sel;
    logic [BW-1:0]       r_dqm;
    logic [AW:1]         r_adr;
    logic [DW-1:0]       r_wdat;
    logic [NREG*DW-1:0]  r_rdat;
    logic [NREG-1:0]     r_ack;
    logic [NREG-1:0]     r_ready;
    logic [NREG-1:0]     r_rst_n;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_prev = 1'b0;

    mem_region_router #(
        .NREG    (NREG),
        .AW      (AW),
        .DW      (DW),
        .BASE    ({21'h010000, 21'h000000}),
        .TMO     (TMO),
        .RST_DLY (RST_DLY)
    ) dut (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .m_reset (m_reset),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_adr   (m_adr),
        .m_out   (m_out),
        .m_dat   (m_dat),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_ready (m_ready),
        .r_stb   (r_stb),
        .r_we    (r_we),
        .r_sel   (r_sel),
        .r_dqm   (r_dqm),
        .r_adr   (r_adr),
        .r_wdat  (r_wdat),
        .r_rdat  (r_rdat),
        .r_ack   (r_ack),
        .r_ready (r_ready),
        .r_rst_n (r_rst_n)
    );

    always #5 clk_p = ~clk_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Region 0 starts at word 0, region 1 at word 0x10000.
    function automatic int ref_region(input logic [AW:1] a);
        return (a >= 21'h010000) ? 1 : 0;
    endfunction

    function automatic logic [NREG*DW-1:0] junk_rdat();
        return (NREG*DW)'({$urandom, $urandom});
    endfunction

    // Monitor: every rising m_ack retires one expected response.
    initial begin
        forever begin
            @(negedge clk_p);
            if (m_ack && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected m_ack: got 1 expected no response pending");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_dat", m_dat, mon_e.dat);
                    chk("m_err", m_err, mon_e.err);
                    chk("r_stb low with m_ack", r_stb, 0);
                end
            end
            mon_prev = m_ack;
        end
    end

    task automatic wait_ack_low();
        for (int k = 0; k < 5 && m_ack; k++) @(negedge clk_p);
        chk("m_ack release", m_ack, 0);
    endtask

    task automatic txn(input logic [AW:1] adr, input logic we, input logic [BW-1:0] sel,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                       input int dly, input bit wrong_ack);
        int            ri;
        int            other;
        exp_t          e;
        logic [BW-1:0] edqm;
        ri    = ref_region(adr);
        other = (ri + 1) % NREG;
        edqm  = we ? ~sel : '0;
        @(posedge clk_p); #1;
        m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_out = wd;
        e.dat = we ? '0 : rd;
        e.err = 1'b0;
        exp_q.push_back(e);
        @(posedge clk_p); @(negedge clk_p);
        chk("r_stb onehot", r_stb, NREG'(1) << ri);
        chk("r_dqm", r_dqm, edqm);
        chk("r_adr", r_adr, adr);
        chk("r_we/r_sel", {r_we, r_sel}, {we, sel});
        if (we) chk("r_wdat", r_wdat, wd);
        if (wrong_ack) begin
            r_ack = '0; r_ack[other] = 1'b1;
            @(posedge clk_p); #1 r_ack = '0;
            @(negedge clk_p);
            chk("wrong-region ack ignored", m_ack, 0);
            chk("r_stb held after wrong ack", r_stb, NREG'(1) << ri);
        end
        repeat (dly) @(negedge clk_p);
        r_rdat = junk_rdat();
        r_rdat[ri*DW +: DW] = rd;
        r_ack = '0; r_ack[ri] = 1'b1;
        @(posedge clk_p); #1;
        r_ack = '0;
        r_rdat = junk_rdat();
        @(negedge clk_p);
        chk("m_ack one cycle after r_ack", m_ack, 1);
        @(negedge clk_p);
        chk("m_ack held while m_stb", m_ack, 1);
        m_stb = 1'b0;
        wait_ack_low();
    endtask

    task automatic rst_release_check(input string name);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_p); @(negedge clk_p);
            chk(name, r_rst_n, (k >= RST_DLY + 3) ? {NREG{1'b1}} : '0);
        end
    endtask

    initial begin
        int seen;
        logic [AW:1] a;
        rst_n = 1'b0; m_reset = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = '0;
        m_adr = '0; m_out = '0; r_rdat = '0; r_ack = '0; r_ready = 2'b11;

        // Power-on reset state.
        repeat (3) @(negedge clk_p);
        chk("reset m_dat/m_ack/m_err/m_ready", {m_dat, m_ack, m_err, m_ready}, 0);
        chk("reset r_stb/r_we/r_sel/r_dqm", {r_stb, r_we, r_sel, r_dqm}, 0);
        chk("reset r_adr/r_wdat", {r_adr, r_wdat}, 0);
        chk("reset r_rst_n", r_rst_n, 0);

        // Release: two sync stages, then RST_DLY+1 more cycles to r_rst_n.
        @(posedge clk_p); #1 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_p); @(negedge clk_p);
            chk("r_rst_n release", r_rst_n, (k >= RST_DLY + 3) ? {NREG{1'b1}} : '0);
            chk("m_ready release", m_ready, (k >= RST_DLY + 4) ? 1 : 0);
        end

        // Directed: region 0 read at the top of region 0.
        txn(21'h00FFFF, 1'b0, 2'b11, 16'h0000, 16'hA5A5, 2, 1'b0);
        // Directed: region 1 upper-byte write with a wrong-region ack first.
        txn(21'h010000, 1'b1, 2'b10, 16'h1234, 16'hFFFF, 1, 1'b1);

        // Timeout: no back-end ack.
        @(posedge clk_p); #1;
        m_stb = 1'b1; m_we = 1'b0; m_sel = 2'b11; m_adr = 21'h000100; m_out = '0;
        exp_q.push_back('{dat: '0, err: 1'b1});
        seen = -1;
        for (int k = 1; k <= TMO + 4; k++) begin
            @(posedge clk_p); @(negedge clk_p);
            if (m_ack && seen < 0) seen = k;
        end
        chk("timeout latency", seen, TMO + 1);
        m_stb = 1'b0;
        wait_ack_low();

        // Abort with a same-cycle ack.
        @(posedge clk_p); #1;
        m_stb = 1'b1; m_we = 1'b0; m_sel = 2'b01; m_adr = 21'h012345;
        @(posedge clk_p); @(negedge clk_p);
        chk("abort r_stb up", r_stb, 2'b10);
        @(posedge clk_p); #1;
        m_stb = 1'b0; r_ack = 2'b10; r_rdat = junk_rdat();
        @(posedge clk_p); #1 r_ack = '0;
        @(negedge clk_p);
        chk("abort r_stb drop", r_stb, 0);
        chk("abort no m_ack", m_ack, 0);
        repeat (3) @(negedge clk_p);
        chk("abort m_ack stays low", m_ack, 0);

        // Randomised traffic, biased toward the region boundary.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) a = 21'h00FFFE + AW'($urandom_range(0, 3));
            else a = AW'($urandom);
            txn(a, 1'($urandom), BW'($urandom), DW'($urandom), DW'($urandom),
                $urandom_range(0, 5), 1'($urandom_range(0, 3) == 0));
        end

        // Memory reset mid-transaction.
        @(posedge clk_p); #1;
        m_stb = 1'b1; m_we = 1'b1; m_sel = 2'b11; m_adr = 21'h000040; m_out = 16'hBEEF;
        @(posedge clk_p); @(negedge clk_p);
        chk("reset-abort r_stb up", r_stb, 2'b01);
        @(posedge clk_p); #1 m_reset = 1'b1;
        repeat (3) begin @(posedge clk_p); @(negedge clk_p); end
        chk("reset-abort r_stb", r_stb, 0);
        chk("reset-abort r_rst_n", r_rst_n, 0);
        chk("reset-abort no m_ack", m_ack, 0);
        m_stb = 1'b0;
        repeat (2) @(negedge clk_p);
        @(posedge clk_p); #1 m_reset = 1'b0;
        rst_release_check("r_rst_n after m_reset");
        for (int k = 0; k < 10 && !m_ready; k++) @(negedge clk_p);
        chk("m_ready after m_reset", m_ready, 1);
        txn(21'h1FFFFF, 1'b0, 2'b01, 16'h0, 16'h5A3C, 0, 1'b0);

        repeat (4) @(negedge clk_p);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
